// File: rtl/design_sel_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// design_sel_sequencer_if : pad-side select/input bus and conditioned outputs
// Revision: 1.0
// ----------------------------------------------------------------------------
interface design_sel_sequencer_if;
  logic [5:0]  des_sel_raw;
  logic        sync_inputs;
  logic [11:0] io_in_raw;
  logic [5:0]  des_sel;
  logic        des_reset;
  logic [11:0] io_in;
  logic        sel_valid;
  logic        switching;

  modport master (
    output des_sel_raw, sync_inputs, io_in_raw,
    input  des_sel, des_reset, io_in, sel_valid, switching
  );

  modport slave (
    input  des_sel_raw, sync_inputs, io_in_raw,
    output des_sel, des_reset, io_in, sel_valid, switching
  );
endinterface
`default_nettype wire

// File: rtl/design_sel_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// design_sel_sequencer : debounces the design select and sequences a timed
//                        design reset before handing inputs to the new design
// Revision: 1.0
// ----------------------------------------------------------------------------
module design_sel_sequencer #(
  parameter int NUM_DESIGNS   = 64,
  parameter int STABLE_CYCLES = 4,
  parameter int RST_CYCLES    = 8
) (
  input wire logic              clock,
  input wire logic              reset,
  design_sel_sequencer_if.slave bus
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [SW-1:0] c_stab_max = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] c_stab_thr = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] c_rst_last = RW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    PEND = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
  logic [5:0]    cand_q, cand_d;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic [5:0]    des_sel_q, des_sel_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic          des_reset_q, des_reset_d;
  logic          sel_valid_q, sel_valid_d;
  logic          switching_q, switching_d;
  logic [11:0]   io_s1_q, io_s1_d, io_s2_q, io_s2_d;
  logic          stable;
  logic          cand_valid;

  // Synchronizers and the select stability filter
  always_comb begin
    sel_s1_d = bus.des_sel_raw;
    sel_s2_d = sel_s1_q;
    io_s1_d  = bus.io_in_raw;
    io_s2_d  = io_s1_q;
    cand_d     = cand_q;
    stab_cnt_d = stab_cnt_q;
    if (sel_s2_q != cand_q) begin
      cand_d     = sel_s2_q;
      stab_cnt_d = SW'(1);
    end else if (stab_cnt_q != c_stab_max) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end
  end

  assign stable     = (sel_s2_q == cand_q) && (stab_cnt_q >= c_stab_thr);
  assign cand_valid = (32'(cand_q) < NUM_DESIGNS);

  always_comb begin
    state_d   = state_q;
    des_sel_d = des_sel_q;
    rst_cnt_d = rst_cnt_q;
    case (state_q)
      PEND: begin
        if (stable && cand_valid) begin
          des_sel_d = cand_q;
          rst_cnt_d = '0;
          state_d   = RST;
        end
      end
      RST: begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        // A newly settled select restarts the reset window rather than finishing it
        if (stable && (cand_q != des_sel_q)) begin
          if (cand_valid) begin
            des_sel_d = cand_q;
            rst_cnt_d = '0;
          end else begin
            state_d = PEND;
          end
        end else if (rst_cnt_q == c_rst_last) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stable && (cand_q != des_sel_q)) begin
          if (cand_valid) begin
            des_sel_d = cand_q;
            rst_cnt_d = '0;
            state_d   = RST;
          end else begin
            state_d = PEND;
          end
        end
      end
      default: state_d = PEND;
    endcase
    des_reset_d = (state_d != RUN);
    sel_valid_d = (state_d == RUN);
    switching_d = (state_d != RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= PEND;
      sel_s1_q    <= '0;
      sel_s2_q    <= '0;
      cand_q      <= '0;
      stab_cnt_q  <= '0;
      des_sel_q   <= '0;
      rst_cnt_q   <= '0;
      des_reset_q <= 1'b1;
      sel_valid_q <= 1'b0;
      switching_q <= 1'b1;
      io_s1_q     <= '0;
      io_s2_q     <= '0;
    end else begin
      state_q     <= state_d;
      sel_s1_q    <= sel_s1_d;
      sel_s2_q    <= sel_s2_d;
      cand_q      <= cand_d;
      stab_cnt_q  <= stab_cnt_d;
      des_sel_q   <= des_sel_d;
      rst_cnt_q   <= rst_cnt_d;
      des_reset_q <= des_reset_d;
      sel_valid_q <= sel_valid_d;
      switching_q <= switching_d;
      io_s1_q     <= io_s1_d;
      io_s2_q     <= io_s2_d;
    end
  end

  assign bus.des_sel   = des_sel_q;
  assign bus.des_reset = des_reset_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.switching = switching_q;
  // Inputs are held at zero while the design is in reset, whichever path is selected
  assign bus.io_in     = des_reset_q ? '0 : (bus.sync_inputs ? io_s2_q : bus.io_in_raw);
endmodule
`default_nettype wire

// File: tb/tb_design_sel_sequencer.sv
`default_nettype none
// tb_design_sel_sequencer : directed steps with a cycle-stamped expectation queue
module tb_design_sel_sequencer;
  localparam int F_SEL = 0;
  localparam int F_RST = 1;
  localparam int F_VAL = 2;
  localparam int F_SW  = 3;
  localparam int F_IO  = 4;

  typedef struct {
    int          cyc;
    string       tag;
    int          fld;
    logic [11:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [11:0] obs_v;

  design_sel_sequencer_if bus();

  design_sel_sequencer #(
    .NUM_DESIGNS   (10),
    .STABLE_CYCLES (4),
    .RST_CYCLES    (8)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] observe(input int fld);
    case (fld)
      F_SEL:   return {6'd0, bus.des_sel};
      F_RST:   return {11'd0, bus.des_reset};
      F_VAL:   return {11'd0, bus.sel_valid};
      F_SW:    return {11'd0, bus.switching};
      F_IO:    return bus.io_in;
      default: return '0;
    endcase
  endfunction

  // Pop every expectation stamped for the current edge, mid-cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        obs_v = observe(sb[i].fld);
        checks++;
        assert (obs_v === sb[i].val) else begin
          errors++;
          $error("FAIL %s (edge %0d) observed %h expected %h", sb[i].tag, cyc, obs_v, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input int c, input string tag, input int fld, input logic [11:0] v);
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.fld = fld;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_st(input int c, input string tag, input logic [5:0] sel,
                         input logic r, input logic v, input logic sw);
    push(c, {tag, ".des_sel"},   F_SEL, {6'd0, sel});
    push(c, {tag, ".des_reset"}, F_RST, {11'd0, r});
    push(c, {tag, ".sel_valid"}, F_VAL, {11'd0, v});
    push(c, {tag, ".switching"}, F_SW,  {11'd0, sw});
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, p, q, r, v, w, x, y;
    rst = 1'b1;
    bus.des_sel_raw = 6'd0;
    bus.sync_inputs = 1'b1;
    bus.io_in_raw   = 12'h000;
    ticks(3);
    push_st(cyc, "reset", 6'd0, 1'b1, 1'b0, 1'b1);
    push(cyc, "reset.io_in", F_IO, 12'h000);
    ticks(1);

    // Power-up with a constant select of 3
    base = cyc;
    push_st(base + 5,  "pwr_e5",  6'd0, 1'b1, 1'b0, 1'b1);
    push_st(base + 6,  "pwr_e6",  6'd3, 1'b1, 1'b0, 1'b1);
    push(base + 6, "pwr_e6.io_in", F_IO, 12'h000);
    push_st(base + 13, "pwr_e13", 6'd3, 1'b1, 1'b0, 1'b1);
    push(base + 13, "pwr_e13.io_in", F_IO, 12'h000);
    push_st(base + 14, "pwr_e14", 6'd3, 1'b0, 1'b1, 1'b0);
    push(base + 14, "pwr_e14.io_in", F_IO, 12'hA5C);
    bus.des_sel_raw = 6'd3;
    bus.io_in_raw   = 12'hA5C;
    rst = 1'b0;
    ticks(16);

    // Two-cycle glitch to 5 must be ignored
    p = cyc;
    for (int k = 1; k <= 12; k++) push_st(p + k, "glitch", 6'd3, 1'b0, 1'b1, 1'b0);
    bus.des_sel_raw = 6'd5;
    ticks(2);
    bus.des_sel_raw = 6'd3;
    ticks(10);

    // Switch 3 -> 9
    q = cyc;
    push_st(q + 5, "switch_e5", 6'd3, 1'b0, 1'b1, 1'b0);
    push(q + 5, "switch_e5.io_in", F_IO, 12'hA5C);
    push_st(q + 6, "switch_e6", 6'd9, 1'b1, 1'b0, 1'b1);
    for (int k = 6; k <= 13; k++) begin
      push(q + k, "switch_win.io_in", F_IO, 12'h000);
      push(q + k, "switch_win.des_reset", F_RST, 12'h001);
    end
    push_st(q + 14, "switch_e14", 6'd9, 1'b0, 1'b1, 1'b0);
    push(q + 14, "switch_e14.io_in", F_IO, 12'hA5C);
    bus.des_sel_raw = 6'd9;
    ticks(16);

    // Input path: synchronized latency, passthrough, live mode toggle
    r = cyc;
    push(r + 1, "sync_e1.io_in",  F_IO, 12'hA5C);
    push(r + 2, "sync_e2.io_in",  F_IO, 12'h5A3);
    push(r + 3, "pass.io_in",     F_IO, 12'h0F0);
    push(r + 4, "resync.io_in",   F_IO, 12'h5A3);
    push(r + 5, "resync2.io_in",  F_IO, 12'h0F0);
    bus.io_in_raw = 12'h5A3;
    ticks(3);
    bus.sync_inputs = 1'b0;
    bus.io_in_raw   = 12'h0F0;
    ticks(1);
    bus.sync_inputs = 1'b1;
    ticks(2);

    // Invalid select 12 parks in PEND, then 2 recovers
    v = cyc;
    push_st(v + 5,  "inval_e5",  6'd9, 1'b0, 1'b1, 1'b0);
    push_st(v + 6,  "inval_e6",  6'd9, 1'b1, 1'b0, 1'b1);
    push_st(v + 20, "inval_e20", 6'd9, 1'b1, 1'b0, 1'b1);
    push(v + 20, "inval_e20.io_in", F_IO, 12'h000);
    bus.des_sel_raw = 6'd12;
    ticks(20);
    w = cyc;
    push_st(w + 5,  "recov_e5",  6'd9, 1'b1, 1'b0, 1'b1);
    push_st(w + 6,  "recov_e6",  6'd2, 1'b1, 1'b0, 1'b1);
    push_st(w + 13, "recov_e13", 6'd2, 1'b1, 1'b0, 1'b1);
    push_st(w + 14, "recov_e14", 6'd2, 1'b0, 1'b1, 1'b0);
    bus.des_sel_raw = 6'd2;
    ticks(16);

    // Reset asserted with rst_cnt at 4, then a full power-up sequence
    x = cyc;
    push_st(x + 6,  "midrst_e6",  6'd7, 1'b1, 1'b0, 1'b1);
    push_st(x + 10, "midrst_e10", 6'd7, 1'b1, 1'b0, 1'b1);
    push_st(x + 11, "midrst_rst", 6'd0, 1'b1, 1'b0, 1'b1);
    push(x + 11, "midrst_rst.io_in", F_IO, 12'h000);
    bus.des_sel_raw = 6'd7;
    ticks(10);
    rst = 1'b1;
    ticks(1);
    rst = 1'b0;
    y = cyc;
    push_st(y + 5,  "repwr_e5",  6'd0, 1'b1, 1'b0, 1'b1);
    push_st(y + 6,  "repwr_e6",  6'd7, 1'b1, 1'b0, 1'b1);
    push_st(y + 13, "repwr_e13", 6'd7, 1'b1, 1'b0, 1'b1);
    push_st(y + 14, "repwr_e14", 6'd7, 1'b0, 1'b1, 1'b0);
    push(y + 14, "repwr_e14.io_in", F_IO, 12'h0F0);
    ticks(16);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
